// File: rtl/serial_rx_pkg.sv
`timescale 1ns/1ps
// Shared types and default sizing for the serial receive framer.
package serial_rx_pkg;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/serial_rx_framer_if.sv
`timescale 1ns/1ps
// Byte output handshake: the framer is the master, the consumer the slave.
interface serial_rx_framer_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/rx_bit_timer.sv
`timescale 1ns/1ps
// Bit-period timer: ticks half a bit after clear (start-bit centre), then once per bit.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic first_half,
    output logic sample_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sample_tick = !clear && (cnt_q == (first_half ? HALF_LAST : FULL_LAST));
        cnt_d       = cnt_q + CW'(1);
        if (clear || sample_tick) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_rx_framer.sv
`timescale 1ns/1ps
// UART-style frame receiver: start-bit confirm, LSB-first payload, stop check,
// and a single-entry valid/ready output register with overrun/framing flags.
module serial_rx_framer
    import serial_rx_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_pulse,
    input  logic               serial_in,
    serial_rx_framer_if.master rx,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun
);
    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 tick;

    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .clear       (state_q == RX_IDLE),
        .first_half  (state_q == RX_START),
        .sample_tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        // Accept first so a byte landing on the same edge sees a free slot.
        if (valid_q && rx.data_ready) valid_d = 1'b0;
        case (state_q)
            RX_IDLE: if (start_pulse) state_d = RX_START;
            RX_START: if (tick) begin
                if (!serial_in) begin
                    state_d = RX_DATA;
                    idx_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: if (tick) begin
                sh_d = {serial_in, sh_q[DATA_BITS-1:1]};
                if (idx_q == LAST_IDX) state_d = RX_STOP;
                else                   idx_d   = idx_q + IW'(1);
            end
            RX_STOP: if (tick) begin
                state_d = RX_IDLE;
                if (!serial_in)   ferr_d = 1'b1;
                else if (valid_d) ovr_d  = 1'b1;
                else begin
                    dout_d  = sh_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.data_out   = dout_q;
    assign rx.data_valid = valid_q;
    assign busy          = busy_q;
    assign frame_err     = ferr_q;
    assign overrun       = ovr_q;
endmodule
